mario_mmio_ctrl: RTL and testbench
==================================

# mario_mmio_ctrl

Parametrised memory-mapped control block for the Mario Bros main-CPU I/O page. It generalises the 74LS259 addressable-latch ports and the single 74LS374 sound-data latch. It provides `LATCH_CH` independent 8-bit addressable latch banks with clear mode, a `FIFO_DEPTH`-entry sound-command queue that replaces the overwrite-prone latch, and a VBLANK NMI generator gated by a latch bit. It sits between the address decoder (which supplies active-low selects) and the sound/video consumers.

## Interface
Parameters:
- `LATCH_CH`, 2: number of 8-bit addressable latch banks (1..8).
- `FIFO_DEPTH`, 4: sound-command queue depth (power of 2, 1..16).
- `OVWR`, 0: full-queue push policy. 0 drops the new byte; 1 overwrites the newest entry.
- `NMI_BIT`, 4: bit of latch bank 0 used as the NMI enable/clear.

Ports:
- `I_CLK_48M`  in  1  system clock.
- `I_RESET_n`  in  1  reset: asynchronous, active-low. Clock is `I_CLK_48M`.
- `I_CEN_12M`  in  1  latch-write clock enable.
- `I_AB`  in  3  CPU address bits [2:0]; selects the latch bit.
- `I_DB`  in  8  CPU data bus.
- `I_LATCH_SEL_n`  in  LATCH_CH  per-bank write select, active-low.
- `I_LATCH_CLR_n`  in  LATCH_CH  per-bank clear, active-low, synchronous.
- `I_SND_WR_n`  in  1  sound-command write strobe, active-low.
- `I_SND_ACK`  in  1  consumer pop request; one cycle per byte.
- `I_OVF_CLR`  in  1  clears the sticky overflow flag.
- `I_VBLK_n`  in  1  vertical blank, active-low.
- `O_LATCH_Q`  out  8*LATCH_CH  latch banks. Bank k is at bits [8k+7:8k].
- `O_SND_DATA`  out  8  queue head.
- `O_SND_VALID`  out  1  queue not empty.
- `O_SND_FULL`  out  1  queue full.
- `O_SND_OVF`  out  1  sticky overflow flag.
- `O_NMI_n`  out  1  NMI to the CPU, active-low.

## Operation
Latch banks (74LS259 behaviour, per bank k):
- On a `I_CEN_12M` cycle with `I_LATCH_SEL_n[k]`=0, bit `I_AB` is written with `I_DB[0]`. Other bits hold.
- `I_LATCH_CLR_n[k]`=0 with select high clears the whole bank on the next clock. This does not wait for `I_CEN_12M`.
- Clear and select low at the same time puts the bank in 259 demux mode: bit `I_AB` is set to `I_DB[0]` and all other bits go to 0, on a `I_CEN_12M` cycle.

Sound-command queue:
- A push is detected on the rising edge of `I_SND_WR_n` (previous sample 0, current 1). In that detect cycle `I_DB` is captured.
- Pop happens on `I_SND_ACK`=1 with `O_SND_VALID`=1. `I_SND_ACK` while empty is ignored.
- Push and pop in the same cycle:
  - not empty: both take effect, and the count is unchanged.
  - empty: the push takes effect and the pop is ignored.
- Push when full without a pop:
  - `OVWR`=0: the byte is dropped and `O_SND_OVF` is set.
  - `OVWR`=1: the tail entry is replaced and `O_SND_OVF` is set.
- `O_SND_OVF` stays set until `I_OVF_CLR` or reset. If set and clear happen in the same cycle, set wins.
- Pointers are log2(`FIFO_DEPTH`) bits and wrap modulo the depth. The count is log2(`FIFO_DEPTH`)+1 bits.

NMI:
- `I_VBLK_n` is sampled. Its falling edge (VBLANK start) drives `O_NMI_n` low if bank 0 bit `NMI_BIT`=1.
- While that bit is 0, `O_NMI_n` is forced to 1.
- If the edge and enable=0 occur in the same cycle, clear wins.

## Timing
- Reset values:
  - `O_LATCH_Q`: all 0.
  - `O_SND_VALID`, `O_SND_FULL`, `O_SND_OVF`: 0.
  - `O_SND_DATA`: 0x00.
  - `O_NMI_n`: 1.
  - Queue empty; edge detectors preset to idle (WR high, VBLK high).
- Latch: the output changes on the clock edge ending the `I_CEN_12M` cycle, so latency is 1 clock.
- Queue:
  - After the push-detect edge, `O_SND_VALID`/`O_SND_FULL`/`O_SND_DATA` update 1 clock later.
  - After a pop, the next head appears 1 clock later.
  - All outputs are registered.
- NMI: `O_NMI_n` goes low 2 clocks after `I_VBLK_n` falls (1 clock to sample, 1 to register). It returns high 1 clock after the enable bit reads 0.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Any pending queue contents are lost.

## Structure
- Package `mario_mmio_pkg`: the `FIFO_AW` = $clog2(`FIFO_DEPTH`) function/constant, and the `OVWR_DROP`/`OVWR_REPLACE` localparams.
- Sub-module `mario_cmd_fifo`: the synchronous queue with its push/pop/overflow logic, parametrised on depth and `OVWR`.
- Latch banks are a generate loop in the top level.

## Test plan
- Reset, then write 1 to addr 4 of bank 0 (`I_DB`=0x01) -> `O_LATCH_Q[7:0]`=0x10. Then hold `I_LATCH_CLR_n[0]` low -> 0x00 the next clock.
- Bank 1 preset 0xFF, then demux mode with `I_AB`=2 and `I_DB[0]`=1 -> `O_LATCH_Q[15:8]`=0x04.
- `FIFO_DEPTH`=4: push 0x11, 0x22, 0x33, 0x44 -> `O_SND_FULL`=1.
  - Push 0x55 -> with `OVWR`=0, pops return 11,22,33,44 and `O_SND_OVF`=1; with `OVWR`=1, pops return 11,22,33,55.
- Full queue with push and pop in the same cycle -> FULL stays 1, OVF stays 0, order preserved.
- Enable=1, then `I_VBLK_n` falls -> `O_NMI_n`=0 after 2 clocks. Write enable=0 -> `O_NMI_n`=1. A VBLANK edge with enable=0 -> no NMI.
- Assert reset with 3 entries queued and NMI low -> VALID=0, `O_NMI_n`=1, all latches 0.

Source files
------------

// File: rtl/mario_mmio_pkg.sv
`default_nettype none
// ============================================================================
// mario_mmio_pkg : shared constants and helpers for the Mario main-CPU I/O page
// Revision      : 1.0
// ============================================================================
package mario_mmio_pkg;

    localparam int OVWR_DROP    = 0;
    localparam int OVWR_REPLACE = 1;

    // A single-entry queue still needs a one-bit pointer to keep ports legal.
    function automatic int fifo_aw(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mario_cmd_fifo.sv
`default_nettype none
// ============================================================================
// mario_cmd_fifo : sound-command queue with sticky overflow and drop/replace
// Revision       : 1.0
// ============================================================================
module mario_cmd_fifo
    import mario_mmio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OVWR  = OVWR_DROP
) (
    input  logic       I_CLK_48M,
    input  logic       I_RESET_n,
    input  logic       i_push,
    input  logic       i_pop_req,
    input  logic       i_ovf_clr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_full,
    output logic       o_ovf
);

    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_data;
    logic          r_valid, r_full, r_ovf;

    logic          w_pop, w_push_ok, w_full_push, w_wr_en;
    logic [AW-1:0] w_wr_addr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_head_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == c_last) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? c_last : p - AW'(1);
    endfunction

    always_comb begin
        w_pop        = i_pop_req & r_valid;
        w_push_ok    = i_push & (~r_full | w_pop);
        w_full_push  = i_push & r_full & ~w_pop;
        w_wr_en      = w_push_ok;
        w_wr_addr    = r_wr_ptr;
        // Replace policy rewrites the newest entry without moving any pointer.
        if (w_full_push && (OVWR == OVWR_REPLACE)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = ptr_dec(r_wr_ptr);
        end
        w_wr_ptr_nxt = w_push_ok ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        w_head_nxt = (w_wr_en && (w_wr_addr == w_rd_ptr_nxt)) ? i_data : r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge I_CLK_48M) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_data;
        end
    end

    always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_data   <= w_head_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_full   <= (w_count_nxt == c_depth);
            if (w_full_push) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_full  = r_full;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mario_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// mario_mmio_ctrl : 74LS259-style latch banks, sound-command queue, VBLANK NMI
// Revision        : 1.0
// ============================================================================
module mario_mmio_ctrl
    import mario_mmio_pkg::*;
#(
    parameter int LATCH_CH   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OVWR       = OVWR_DROP,
    parameter int NMI_BIT    = 4
) (
    input  logic                  I_CLK_48M,
    input  logic                  I_RESET_n,
    input  logic                  I_CEN_12M,
    input  logic [2:0]            I_AB,
    input  logic [7:0]            I_DB,
    input  logic [LATCH_CH-1:0]   I_LATCH_SEL_n,
    input  logic [LATCH_CH-1:0]   I_LATCH_CLR_n,
    input  logic                  I_SND_WR_n,
    input  logic                  I_SND_ACK,
    input  logic                  I_OVF_CLR,
    input  logic                  I_VBLK_n,
    output logic [8*LATCH_CH-1:0] O_LATCH_Q,
    output logic [7:0]            O_SND_DATA,
    output logic                  O_SND_VALID,
    output logic                  O_SND_FULL,
    output logic                  O_SND_OVF,
    output logic                  O_NMI_n
);

    logic [7:0] w_demux;
    assign w_demux = 8'(I_DB[0]) << I_AB;

    for (genvar k = 0; k < LATCH_CH; k++) begin : g_latch
        logic [7:0] r_q;
        always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
            if (!I_RESET_n) begin
                r_q <= 8'h00;
            end else if (!I_LATCH_CLR_n[k] && I_LATCH_SEL_n[k]) begin
                r_q <= 8'h00;
            end else if (I_CEN_12M && !I_LATCH_SEL_n[k]) begin
                if (!I_LATCH_CLR_n[k]) begin
                    r_q <= w_demux;
                end else begin
                    r_q[I_AB] <= I_DB[0];
                end
            end
        end
        assign O_LATCH_Q[8*k +: 8] = r_q;
    end

    logic r_snd_wr_prev;
    logic w_push;
    assign w_push = ~r_snd_wr_prev & I_SND_WR_n;

    always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_snd_wr_prev <= 1'b1;
        end else begin
            r_snd_wr_prev <= I_SND_WR_n;
        end
    end

    mario_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .OVWR  (OVWR)
    ) u_cmd_fifo (
        .I_CLK_48M (I_CLK_48M),
        .I_RESET_n (I_RESET_n),
        .i_push    (w_push),
        .i_pop_req (I_SND_ACK),
        .i_ovf_clr (I_OVF_CLR),
        .i_data    (I_DB),
        .o_data    (O_SND_DATA),
        .o_valid   (O_SND_VALID),
        .o_full    (O_SND_FULL),
        .o_ovf     (O_SND_OVF)
    );

    // VBLANK is sampled once, then compared with its delayed copy for the edge.
    logic r_vblk_s, r_vblk_d, r_nmi_n;
    logic w_nmi_en, w_vblk_fall;
    assign w_nmi_en    = O_LATCH_Q[NMI_BIT];
    assign w_vblk_fall = r_vblk_d & ~r_vblk_s;

    always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_vblk_s <= 1'b1;
            r_vblk_d <= 1'b1;
            r_nmi_n  <= 1'b1;
        end else begin
            r_vblk_s <= I_VBLK_n;
            r_vblk_d <= r_vblk_s;
            if (!w_nmi_en) begin
                r_nmi_n <= 1'b1;
            end else if (w_vblk_fall) begin
                r_nmi_n <= 1'b0;
            end
        end
    end

    assign O_NMI_n = r_nmi_n;

endmodule
`default_nettype wire

// File: tb/tb_mario_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mario_mmio_ctrl : drop- and replace-policy instances driven side by side
// Revision           : 1.0
// ============================================================================
module tb_mario_mmio_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, cen, wr_n, ack, ovf_clr, vblk_n;
    logic [2:0]  ab;
    logic [7:0]  db;
    logic [1:0]  sel_n, clr_n;

    logic [15:0] lat_a, lat_b;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, full_a, full_b, ovf_a, ovf_b, nmi_a, nmi_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_lat [2];
    logic [7:0] qa[$], qb[$], wq[$];
    bit         ovf_ma, ovf_mb, wovf, m_wr_prev;

    always #5 clk = ~clk;

    mario_mmio_ctrl #(.LATCH_CH(2), .FIFO_DEPTH(DEPTH), .OVWR(0), .NMI_BIT(4)) u_dut_drop (
        .I_CLK_48M(clk), .I_RESET_n(rst_n), .I_CEN_12M(cen), .I_AB(ab), .I_DB(db),
        .I_LATCH_SEL_n(sel_n), .I_LATCH_CLR_n(clr_n), .I_SND_WR_n(wr_n), .I_SND_ACK(ack),
        .I_OVF_CLR(ovf_clr), .I_VBLK_n(vblk_n), .O_LATCH_Q(lat_a), .O_SND_DATA(data_a),
        .O_SND_VALID(valid_a), .O_SND_FULL(full_a), .O_SND_OVF(ovf_a), .O_NMI_n(nmi_a)
    );

    mario_mmio_ctrl #(.LATCH_CH(2), .FIFO_DEPTH(DEPTH), .OVWR(1), .NMI_BIT(4)) u_dut_ovwr (
        .I_CLK_48M(clk), .I_RESET_n(rst_n), .I_CEN_12M(cen), .I_AB(ab), .I_DB(db),
        .I_LATCH_SEL_n(sel_n), .I_LATCH_CLR_n(clr_n), .I_SND_WR_n(wr_n), .I_SND_ACK(ack),
        .I_OVF_CLR(ovf_clr), .I_VBLK_n(vblk_n), .O_LATCH_Q(lat_b), .O_SND_DATA(data_b),
        .O_SND_VALID(valid_b), .O_SND_FULL(full_b), .O_SND_OVF(ovf_b), .O_NMI_n(nmi_b)
    );

    task automatic model_reset();
        m_lat[0] = 8'h00;
        m_lat[1] = 8'h00;
        qa.delete();
        qb.delete();
        ovf_ma = 1'b0;
        ovf_mb = 1'b0;
        m_wr_prev = 1'b1;
    endtask

    // Queue rules applied to the working copy wq/wovf.
    task automatic fifo_rule(input bit ovwr, input bit push, input bit pop_req,
                             input bit clr, input logic [7:0] d);
        bit pop, full;
        pop  = pop_req && (wq.size() > 0);
        full = (wq.size() == DEPTH);
        if (push && full && !pop) begin
            wovf = 1'b1;
            if (ovwr) wq[wq.size()-1] = d;
        end else begin
            if (pop) void'(wq.pop_front());
            if (push) wq.push_back(d);
            if (clr) wovf = 1'b0;
        end
    endtask

    // Predict the next clock edge from the current inputs, then advance to the falling edge.
    task automatic tick();
        bit push;
        for (int k = 0; k < 2; k++) begin
            if (!clr_n[k] && sel_n[k]) begin
                m_lat[k] = 8'h00;
            end else if (cen && !sel_n[k]) begin
                if (!clr_n[k]) m_lat[k] = 8'h00;
                m_lat[k][ab] = db[0];
            end
        end
        push = !m_wr_prev && wr_n;
        m_wr_prev = wr_n;
        wq = qa; wovf = ovf_ma; fifo_rule(1'b0, push, ack, ovf_clr, db); qa = wq; ovf_ma = wovf;
        wq = qb; wovf = ovf_mb; fifo_rule(1'b1, push, ack, ovf_clr, db); qb = wq; ovf_mb = wovf;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cen = 0; ab = 0; db = 0; sel_n = 2'b11; clr_n = 2'b11;
        wr_n = 1; ack = 0; ovf_clr = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_n = 0; tick();
        wr_n = 1; db = b; tick();
    endtask

    task automatic latch_write(input int bank, input logic [2:0] a, input logic d);
        cen = 1; ab = a; db = {7'h0, d}; sel_n = 2'b11; sel_n[bank] = 1'b0;
        tick();
        cen = 0; sel_n = 2'b11;
    endtask

    task automatic drain();
        ack = 1;
        repeat (DEPTH + 1) tick();
        ack = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (lat_a !== 16'h0 || lat_b !== 16'h0) begin
            errors++; $display("FAIL reset_latch: got %h/%h want 0000", lat_a, lat_b);
        end
        checks++;
        if ({valid_a, full_a, ovf_a, valid_b, full_b, ovf_b} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                               {valid_a, full_a, ovf_a, valid_b, full_b, ovf_b});
        end
        checks++;
        if (data_a !== 8'h00 || nmi_a !== 1'b1 || nmi_b !== 1'b1) begin
            errors++; $display("FAIL reset_data_nmi: got data=%h nmi=%b%b want 00 11", data_a, nmi_a, nmi_b);
        end
        rst_n = 1;
        tick();
        checks++;
        if (valid_a !== 1'b0 || nmi_a !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle: got valid=%b nmi=%b want 0 1", valid_a, nmi_a);
        end
    endtask

    task automatic test_latch_basic();
        latch_write(0, 3'd4, 1'b1);
        checks++;
        if (lat_a[7:0] !== 8'h10 || lat_a !== {m_lat[1], m_lat[0]}) begin
            errors++; $display("FAIL latch_write: got %h want 10", lat_a[7:0]);
        end
        clr_n = 2'b10; tick(); clr_n = 2'b11;
        checks++;
        if (lat_a[7:0] !== 8'h00) begin
            errors++; $display("FAIL latch_clear: got %h want 00", lat_a[7:0]);
        end
    endtask

    task automatic test_demux();
        for (int i = 0; i < 8; i++) latch_write(1, 3'(i), 1'b1);
        checks++;
        if (lat_a[15:8] !== 8'hFF) begin
            errors++; $display("FAIL latch_preset: got %h want ff", lat_a[15:8]);
        end
        cen = 1; sel_n = 2'b01; clr_n = 2'b01; ab = 3'd2; db = 8'h01;
        tick();
        idle_inputs();
        checks++;
        if (lat_a !== 16'h0400 || lat_b !== 16'h0400) begin
            errors++; $display("FAIL latch_demux: got %h/%h want 0400", lat_a, lat_b);
        end
    endtask

    task automatic test_latch_random();
        for (int i = 0; i < 150; i++) begin
            cen   = 1'($urandom_range(0, 1));
            sel_n = 2'($urandom_range(0, 3));
            clr_n = 2'b11;
            if ($urandom_range(0, 5) == 0) clr_n[$urandom_range(0, 1)] = 1'b0;
            ab = 3'($urandom_range(0, 7));
            db = 8'($urandom);
            tick();
            checks++;
            if (lat_a !== {m_lat[1], m_lat[0]} || nmi_a !== 1'b1) begin
                errors++; $display("FAIL latch_rand[%0d]: got %h nmi=%b want %h nmi=1",
                                   i, lat_a, nmi_a, {m_lat[1], m_lat[0]});
            end
        end
        idle_inputs();
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h55};
        for (int i = 0; i < 4; i++) push_byte(exp_a[i]);
        checks++;
        if (full_a !== 1 || full_b !== 1 || ovf_a !== 0 || data_a !== 8'h11) begin
            errors++; $display("FAIL fifo_fill: got full=%b%b ovf=%b data=%h want 11 0 11",
                               full_a, full_b, ovf_a, data_a);
        end
        push_byte(8'h55);
        checks++;
        if (ovf_a !== 1 || ovf_b !== 1 || full_a !== 1 || full_b !== 1) begin
            errors++; $display("FAIL fifo_ovf_set: got ovf=%b%b full=%b%b want 11 11",
                               ovf_a, ovf_b, full_a, full_b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_a !== 1 || data_a !== exp_a[i] || valid_b !== 1 || data_b !== exp_b[i]) begin
                errors++; $display("FAIL fifo_pop[%0d]: got %h/%h want %h/%h",
                                   i, data_a, data_b, exp_a[i], exp_b[i]);
            end
            ack = 1; tick(); ack = 0;
        end
        checks++;
        if (valid_a !== 0 || valid_b !== 0 || ovf_a !== 1) begin
            errors++; $display("FAIL fifo_empty_ovf_sticky: got valid=%b%b ovf=%b want 00 1",
                               valid_a, valid_b, ovf_a);
        end
        ack = 1; tick(); ack = 0;
        checks++;
        if (valid_a !== 0 || valid_b !== 0) begin
            errors++; $display("FAIL fifo_ack_empty: got valid=%b%b want 00", valid_a, valid_b);
        end
        ovf_clr = 1; tick(); ovf_clr = 0;
        checks++;
        if (ovf_a !== 0 || ovf_b !== 0) begin
            errors++; $display("FAIL fifo_ovf_clr: got %b%b want 00", ovf_a, ovf_b);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4];
        exp = '{8'h22, 8'h33, 8'h44, 8'h66};
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wr_n = 0; tick();
        wr_n = 1; db = 8'h66; ack = 1; tick(); ack = 0;
        checks++;
        if (full_a !== 1 || full_b !== 1 || ovf_a !== 0 || ovf_b !== 0) begin
            errors++; $display("FAIL full_push_pop_flags: got full=%b%b ovf=%b%b want 11 00",
                               full_a, full_b, ovf_a, ovf_b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_a !== exp[i] || data_b !== exp[i]) begin
                errors++; $display("FAIL full_push_pop_order[%0d]: got %h/%h want %h",
                                   i, data_a, data_b, exp[i]);
            end
            ack = 1; tick(); ack = 0;
        end
    endtask

    task automatic test_fifo_random();
        for (int i = 0; i < 400; i++) begin
            wr_n    = 1'($urandom_range(0, 1));
            db      = 8'($urandom);
            ack     = ($urandom_range(0, 4) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (valid_a !== (qa.size() > 0) || full_a !== (qa.size() == DEPTH) || ovf_a !== ovf_ma ||
                valid_b !== (qb.size() > 0) || full_b !== (qb.size() == DEPTH) || ovf_b !== ovf_mb) begin
                errors++; $display("FAIL fifo_rand_flags[%0d]: got v/f/o=%b%b%b %b%b%b want sizes %0d %0d ovf %b %b",
                                   i, valid_a, full_a, ovf_a, valid_b, full_b, ovf_b,
                                   qa.size(), qb.size(), ovf_ma, ovf_mb);
            end else if ((qa.size() > 0 && data_a !== qa[0]) || (qb.size() > 0 && data_b !== qb[0])) begin
                errors++; $display("FAIL fifo_rand_data[%0d]: got %h/%h want %h/%h", i, data_a, data_b,
                                   (qa.size() > 0) ? qa[0] : 8'h00, (qb.size() > 0) ? qb[0] : 8'h00);
            end
        end
        idle_inputs();
        drain();
        ovf_clr = 1; tick(); ovf_clr = 0;
    endtask

    task automatic test_nmi();
        vblk_n = 1; repeat (3) tick();
        latch_write(0, 3'd4, 1'b1);
        vblk_n = 0; tick();
        checks++;
        if (nmi_a !== 1'b1) begin
            errors++; $display("FAIL nmi_sample_delay: got %b want 1", nmi_a);
        end
        tick();
        checks++;
        if (nmi_a !== 1'b0 || nmi_b !== 1'b0) begin
            errors++; $display("FAIL nmi_assert: got %b%b want 00", nmi_a, nmi_b);
        end
        latch_write(0, 3'd4, 1'b0);
        checks++;
        if (nmi_a !== 1'b0) begin
            errors++; $display("FAIL nmi_release_delay: got %b want 0", nmi_a);
        end
        tick();
        checks++;
        if (nmi_a !== 1'b1) begin
            errors++; $display("FAIL nmi_release: got %b want 1", nmi_a);
        end
        vblk_n = 1; repeat (3) tick();
        vblk_n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (nmi_a !== 1'b1) begin
                errors++; $display("FAIL nmi_masked[%0d]: got %b want 1", i, nmi_a);
            end
        end
        vblk_n = 1; repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        latch_write(0, 3'd4, 1'b1);
        latch_write(1, 3'd7, 1'b1);
        vblk_n = 0; tick(); tick();
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        checks++;
        if (valid_a !== 1 || nmi_a !== 0 || qa.size() != 3) begin
            errors++; $display("FAIL pre_reset_state: got valid=%b nmi=%b want 1 0", valid_a, nmi_a);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (valid_a !== 0 || valid_b !== 0 || full_a !== 0 || nmi_a !== 1 || nmi_b !== 1 ||
            lat_a !== 16'h0 || lat_b !== 16'h0 || data_a !== 8'h00) begin
            errors++; $display("FAIL async_reset: got valid=%b%b nmi=%b%b lat=%h data=%h want 00 11 0000 00",
                               valid_a, valid_b, nmi_a, nmi_b, lat_a, data_a);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1; vblk_n = 1;
        tick(); tick();
        checks++;
        if (valid_a !== 0 || nmi_a !== 1 || lat_a !== 16'h0) begin
            errors++; $display("FAIL post_mid_reset: got valid=%b nmi=%b lat=%h want 0 1 0000",
                               valid_a, nmi_a, lat_a);
        end
    endtask

    initial begin
        rst_n = 0; vblk_n = 1;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_latch_basic();
        test_demux();
        test_latch_random();
        drain();
        test_fifo_overflow();
        test_full_push_pop();
        test_fifo_random();
        test_nmi();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
